rr_mem_port_arbiter: RTL and testbench

//  Round-robin arbiter sharing one pipelined memory port between NR_PORTS requesters.

---
 rtl/soc_arb_pkg.sv | 38 +++
 rtl/arb_id_fifo.sv | 75 +++++++
 rtl/rr_mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_rr_mem_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_arb_pkg.sv
// Shared types, default sizes and width helpers for the round-robin memory port arbiter.
package soc_arb_pkg;

    // Default configuration of the arbiter slice.
    localparam int NR_PORTS_DEF        = 3;
    localparam int DATA_WIDTH_DEF      = 64;
    localparam int MAX_OUTSTANDING_DEF = 4;
    localparam int ADDR_WIDTH          = 64;
    localparam int SIZE_WIDTH          = 2;

    // Width of a port index; never narrower than one bit.
    function automatic int id_width(input int nr_ports);
        return (nr_ports > 1) ? $clog2(nr_ports) : 1;
    endfunction

    // Width of a FIFO read/write pointer for a power-of-two depth.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width of an occupancy counter that must be able to hold the full depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Port index as tracked by the in-flight ID FIFO (default configuration).
    typedef logic [id_width(NR_PORTS_DEF)-1:0] port_id_t;

    // One requester's transaction fields (default configuration).
    typedef struct packed {
        logic [ADDR_WIDTH-1:0]       address;
        logic [DATA_WIDTH_DEF-1:0]   wdata;
        logic [DATA_WIDTH_DEF/8-1:0] be;
        logic [SIZE_WIDTH-1:0]       size;
        logic                        we;
    } mem_req_t;

endpackage

// File: rtl/arb_id_fifo.sv
// Synchronous FIFO of granted port indices. The head entry is visible
// combinationally so a response can be routed in the cycle it arrives.
module arb_id_fifo
    import soc_arb_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    localparam int PW   = ptr_width(DEPTH),
    localparam int CW   = cnt_width(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Next-state: guarded push/pop, pointer wrap by power-of-two overflow, occupancy.
    always_comb begin
        do_push  = push_i & ~full_o;
        do_pop   = pop_i & ~empty_o;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state: pointers and occupancy, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array: contents are only meaningful below the occupancy, so no reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/rr_mem_port_arbiter.sv
// Round-robin arbiter sharing one pipelined memory port between NR_PORTS
// requesters. Up to MAX_OUTSTANDING accepted transactions may be in flight;
// their port indices are queued so in-order responses return to the issuer.
module rr_mem_port_arbiter
    import soc_arb_pkg::*;
#(
    parameter int NR_PORTS        = NR_PORTS_DEF,
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
    localparam int IDW            = id_width(NR_PORTS),
    localparam int BEW            = DATA_WIDTH / 8,
    localparam int CW             = cnt_width(MAX_OUTSTANDING)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    // core side
    input  logic [NR_PORTS-1:0]            data_req_i,
    input  logic [NR_PORTS*ADDR_WIDTH-1:0] address_i,
    input  logic [NR_PORTS*DATA_WIDTH-1:0] data_wdata_i,
    input  logic [NR_PORTS-1:0]            data_we_i,
    input  logic [NR_PORTS*BEW-1:0]        data_be_i,
    input  logic [NR_PORTS*SIZE_WIDTH-1:0] data_size_i,
    output logic [NR_PORTS-1:0]            data_gnt_o,
    output logic [NR_PORTS-1:0]            data_rvalid_o,
    output logic [NR_PORTS*DATA_WIDTH-1:0] data_rdata_o,
    // memory side
    output logic                           data_req_o,
    output logic [ADDR_WIDTH-1:0]          address_o,
    output logic [DATA_WIDTH-1:0]          data_wdata_o,
    output logic                           data_we_o,
    output logic [BEW-1:0]                 data_be_o,
    output logic [SIZE_WIDTH-1:0]          data_size_o,
    output logic [IDW-1:0]                 id_o,
    input  logic                           data_gnt_i,
    input  logic                           data_rvalid_i,
    input  logic [DATA_WIDTH-1:0]          data_rdata_i,
    // status
    output logic [CW-1:0]                  outstanding_o,
    output logic                           err_o
);

    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic           err_q, err_d;
    logic [IDW-1:0] winner;
    logic           any_req;
    logic           accept;
    logic           pop;
    logic [IDW-1:0] head_id;
    logic           fifo_full;
    logic           fifo_empty;

    // Priority search starting at the round-robin pointer, wrapping past the last port.
    always_comb begin
        int j;
        j       = 0;
        winner  = '0;
        any_req = 1'b0;
        for (int i = 0; i < NR_PORTS; i++) begin
            j = int'(rr_ptr_q) + i;
            if (j >= NR_PORTS) begin
                j = j - NR_PORTS;
            end
            if (!any_req && data_req_i[j]) begin
                any_req = 1'b1;
                winner  = IDW'(j);
            end
        end
    end

    // A full ID FIFO blocks new requests, even if a response frees a slot this cycle.
    assign data_req_o = any_req & ~fifo_full;
    assign accept     = data_req_o & data_gnt_i;
    assign pop        = data_rvalid_i & ~fifo_empty;
    assign id_o       = winner;

    // Request mux: forward the winner's fields (port 0 when nobody requests).
    always_comb begin
        int w;
        w            = int'(winner);
        address_o    = address_i[w*ADDR_WIDTH +: ADDR_WIDTH];
        data_wdata_o = data_wdata_i[w*DATA_WIDTH +: DATA_WIDTH];
        data_we_o    = data_we_i[w];
        data_be_o    = data_be_i[w*BEW +: BEW];
        data_size_o  = data_size_i[w*SIZE_WIDTH +: SIZE_WIDTH];
    end

    // Zero-cycle grant back to the winning port only.
    always_comb begin
        data_gnt_o         = '0;
        data_gnt_o[winner] = accept;
    end

    // Response demux: route data to the oldest in-flight port, zero elsewhere.
    always_comb begin
        int h;
        h             = int'(head_id);
        data_rvalid_o = '0;
        data_rdata_o  = '0;
        if (pop) begin
            data_rvalid_o[h]                     = 1'b1;
            data_rdata_o[h*DATA_WIDTH +: DATA_WIDTH] = data_rdata_i;
        end
    end

    // Pointer moves past the accepted port; a stray response latches the error flag.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            if (int'(winner) == NR_PORTS - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = winner + IDW'(1);
            end
        end
        err_d = err_q | (data_rvalid_i & fifo_empty);
    end

    // Arbiter control registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end

    assign err_o = err_q;

    arb_id_fifo #(
        .WIDTH (IDW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (accept),
        .push_data_i (winner),
        .pop_i       (pop),
        .head_o      (head_id),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (outstanding_o)
    );

endmodule

// File: tb/tb_rr_mem_port_arbiter.sv
// Self-checking bench for rr_mem_port_arbiter: a queue-based transaction model
// is checked against every DUT output each cycle, with literal spot checks on
// directed scenarios followed by a randomized run.
module tb_rr_mem_port_arbiter;

    localparam int NR  = 3;
    localparam int DW  = 64;
    localparam int MAXO = 4;
    localparam int BEW = DW / 8;

    logic                clk = 1'b0;
    logic                rst_i;
    logic [NR-1:0]       data_req_i;
    logic [NR*64-1:0]    address_i;
    logic [NR*DW-1:0]    data_wdata_i;
    logic [NR-1:0]       data_we_i;
    logic [NR*BEW-1:0]   data_be_i;
    logic [NR*2-1:0]     data_size_i;
    logic [NR-1:0]       data_gnt_o;
    logic [NR-1:0]       data_rvalid_o;
    logic [NR*DW-1:0]    data_rdata_o;
    logic                data_req_o;
    logic [63:0]         address_o;
    logic [DW-1:0]       data_wdata_o;
    logic                data_we_o;
    logic [BEW-1:0]      data_be_o;
    logic [1:0]          data_size_o;
    logic [1:0]          id_o;
    logic                data_gnt_i;
    logic                data_rvalid_i;
    logic [DW-1:0]       data_rdata_i;
    logic [2:0]          outstanding_o;
    logic                err_o;

    rr_mem_port_arbiter #(
        .NR_PORTS(NR), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .data_req_i(data_req_i), .address_i(address_i), .data_wdata_i(data_wdata_i),
        .data_we_i(data_we_i), .data_be_i(data_be_i), .data_size_i(data_size_i),
        .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .data_req_o(data_req_o), .address_o(address_o), .data_wdata_o(data_wdata_o),
        .data_we_o(data_we_o), .data_be_o(data_be_o), .data_size_o(data_size_o),
        .id_o(id_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
        .data_rdata_i(data_rdata_i), .outstanding_o(outstanding_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // stimulus state
    logic          rst_v, gnt_v, rv_v;
    logic [NR-1:0] req_v;
    logic [DW-1:0] rdata_v;
    logic [63:0]   f_addr [NR];
    logic [DW-1:0] f_wdata [NR];
    logic [BEW-1:0] f_be [NR];
    logic [1:0]    f_size [NR];
    logic          f_we [NR];
    bit            pending [NR];

    // model state
    int model_q[$];
    int mptr;
    bit merr;

    // values computed for the current cycle
    int          s_wi;
    bit          s_accept, s_pop, s_stray;
    logic [NR-1:0] s_gnt;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Raise requests; a port starting a fresh request gets new random fields.
    task automatic set_req(input logic [NR-1:0] mask);
        for (int p = 0; p < NR; p++) begin
            if (mask[p] && !pending[p]) begin
                f_addr[p]  = {$urandom, $urandom};
                f_wdata[p] = {$urandom, $urandom};
                f_be[p]    = BEW'($urandom);
                f_size[p]  = 2'($urandom % 4);
                f_we[p]    = 1'($urandom % 2);
            end
        end
        req_v = mask;
    endtask

    // Drive inputs, let them settle, and compare all outputs against the model.
    task automatic eval(input bit chk_en);
        int w;
        bit exp_req;
        logic [NR-1:0] exp_rv;
        logic [NR*DW-1:0] exp_rd;
        rst_i         = rst_v;
        data_req_i    = req_v;
        data_gnt_i    = gnt_v;
        data_rvalid_i = rv_v;
        data_rdata_i  = rdata_v;
        for (int p = 0; p < NR; p++) begin
            address_i[p*64 +: 64]   = f_addr[p];
            data_wdata_i[p*DW +: DW] = f_wdata[p];
            data_be_i[p*BEW +: BEW] = f_be[p];
            data_size_i[p*2 +: 2]   = f_size[p];
            data_we_i[p]            = f_we[p];
        end
        #1;
        w = -1;
        for (int k = 0; k < NR; k++) begin
            if (w < 0 && req_v[(mptr + k) % NR]) w = (mptr + k) % NR;
        end
        exp_req  = (w >= 0) && (model_q.size() < MAXO);
        s_wi     = (w < 0) ? 0 : w;
        s_accept = exp_req && gnt_v;
        s_gnt    = s_accept ? NR'(1 << s_wi) : '0;
        s_pop    = rv_v && (model_q.size() > 0);
        s_stray  = rv_v && (model_q.size() == 0);
        exp_rv   = '0;
        exp_rd   = '0;
        if (s_pop) begin
            exp_rv[model_q[0]] = 1'b1;
            exp_rd[model_q[0]*DW +: DW] = rdata_v;
        end
        if (chk_en) begin
            chk("req_o", data_req_o, exp_req);
            chk("gnt_o", data_gnt_o, s_gnt);
            chk("id_o", id_o, s_wi);
            chk("address_o", address_o, f_addr[s_wi]);
            chk("wdata_o", data_wdata_o, f_wdata[s_wi]);
            chk("we_o", data_we_o, f_we[s_wi]);
            chk("be_o", data_be_o, f_be[s_wi]);
            chk("size_o", data_size_o, f_size[s_wi]);
            chk("rvalid_o", data_rvalid_o, exp_rv);
            chk("rdata_o", data_rdata_o, exp_rd);
            chk("outstanding_o", outstanding_o, model_q.size());
            chk("err_o", err_o, merr);
        end
    endtask

    // Clock edge: advance the model using the decisions of the cycle just checked.
    task automatic advance();
        @(posedge clk);
        if (rst_v) begin
            model_q.delete();
            mptr = 0;
            merr = 0;
        end else begin
            if (s_pop) void'(model_q.pop_front());
            if (s_stray) merr = 1;
            if (s_accept) begin
                model_q.push_back(s_wi);
                mptr = (s_wi + 1) % NR;
            end
        end
        for (int p = 0; p < NR; p++) pending[p] = req_v[p] && !s_gnt[p];
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        set_req('0);
        gnt_v = 0; rv_v = 0; rdata_v = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_v = 1;
        eval(0); advance();
        eval(0); advance();
        rst_v = 0;
    endtask

    initial begin
        logic [DW-1:0] slice;
        for (int p = 0; p < NR; p++) begin
            pending[p] = 0; f_addr[p] = '0; f_wdata[p] = '0; f_be[p] = '0; f_size[p] = '0; f_we[p] = 0;
        end
        mptr = 0; merr = 0;
        req_v = '0;
        apply_reset();

        // reset then idle
        eval(1);
        chk("idle_req_o", data_req_o, 0);
        chk("idle_gnt_o", data_gnt_o, 0);
        chk("idle_rvalid_o", data_rvalid_o, 0);
        chk("idle_rdata_o", data_rdata_o, 0);
        chk("idle_outstanding", outstanding_o, 0);
        chk("idle_err", err_o, 0);
        advance();

        // all ports requesting, responses one cycle behind
        apply_reset();
        for (int n = 0; n < 8; n++) begin
            set_req(3'b111);
            gnt_v   = (n < 6);
            rv_v    = (n >= 1 && n <= 6);
            rdata_v = DW'(32'hA0 + n - 1);
            eval(1);
            if (n < 6) chk("rr_gnt_seq", data_gnt_o, 3'b001 << (n % 3));
            if (rv_v) begin
                chk("rr_rvalid_seq", data_rvalid_o, 3'b001 << ((n - 1) % 3));
                slice = data_rdata_o[((n - 1) % 3)*DW +: DW];
                chk("rr_rdata_seq", slice, 32'hA0 + n - 1);
            end
            advance();
        end

        // fill to MAX_OUTSTANDING, then drain one
        apply_reset();
        set_req(3'b111); gnt_v = 1;
        for (int n = 0; n < 4; n++) begin eval(1); advance(); set_req(3'b111); end
        eval(1);
        chk("full_req_o", data_req_o, 0);
        chk("full_count", outstanding_o, 4);
        advance();
        rv_v = 1; rdata_v = 64'h55;
        eval(1);
        chk("full_pop_bubble", data_req_o, 0);
        advance();
        rv_v = 0;
        eval(1);
        chk("after_pop_count", outstanding_o, 3);
        chk("after_pop_req_o", data_req_o, 1);
        advance();
        set_req('0); gnt_v = 0; rv_v = 1;
        for (int n = 0; n < 4; n++) begin eval(1); advance(); end
        rv_v = 0;

        // port 2 stalled by downstream, then accepted
        apply_reset();
        set_req(3'b100); gnt_v = 0;
        for (int n = 0; n < 3; n++) begin
            eval(1);
            chk("stall_req_o", data_req_o, 1);
            chk("stall_id_o", id_o, 2);
            chk("stall_gnt_o", data_gnt_o, 0);
            advance();
        end
        gnt_v = 1;
        eval(1);
        chk("stall_release_gnt", data_gnt_o, 3'b100);
        advance();
        set_req(3'b101); gnt_v = 0;
        eval(1);
        chk("ptr_wrapped_id", id_o, 0);
        advance();
        set_req('0); rv_v = 1; eval(1); advance(); rv_v = 0;

        // simultaneous accept and response at count 2
        apply_reset();
        set_req(3'b001); gnt_v = 1;
        eval(1); advance();
        set_req(3'b001);
        eval(1); advance();
        set_req(3'b010); rv_v = 1; rdata_v = 64'hBEEF;
        eval(1);
        chk("both_count_before", outstanding_o, 2);
        chk("both_rvalid", data_rvalid_o, 3'b001);
        chk("both_gnt", data_gnt_o, 3'b010);
        advance();
        set_req('0); gnt_v = 0; rv_v = 0;
        eval(1);
        chk("both_count_after", outstanding_o, 2);
        advance();
        rv_v = 1; eval(1); advance(); eval(1); advance(); rv_v = 0;

        // stray response sets sticky error
        apply_reset();
        rv_v = 1; rdata_v = 64'h1234;
        eval(1);
        chk("stray_rvalid_o", data_rvalid_o, 0);
        advance();
        rv_v = 0;
        for (int n = 0; n < 3; n++) begin
            eval(1);
            chk("err_sticky", err_o, 1);
            advance();
        end
        rst_v = 1; eval(1); advance(); rst_v = 0;
        eval(1);
        chk("err_cleared", err_o, 0);
        advance();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            logic [NR-1:0] m;
            m = NR'($urandom);
            for (int p = 0; p < NR; p++) if (pending[p]) m[p] = 1'b1;
            set_req(m);
            gnt_v   = 1'($urandom % 3 != 0);
            rv_v    = (model_q.size() > 0) ? 1'($urandom % 2) : ($urandom % 300 == 0);
            rdata_v = {$urandom, $urandom};
            rst_v   = ($urandom % 250 == 0);
            eval(1);
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
